// File: rtl/rs_encoder_15_11.sv
// Systematic RS(15,11) serial encoder over GF(16), p(x) = x^4 + x + 1, one output register stage.
// Optional error injection on the output symbols is enabled by defining RS_ENC_ERR_INJECT_EN.
module rs_encoder_15_11 #(
    parameter logic [3:0] G3 = 4'hF,
    parameter logic [3:0] G2 = 4'h3,
    parameter logic [3:0] G1 = 4'h1,
    parameter logic [3:0] G0 = 4'hC
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] in_symbol_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic [3:0] out_serial_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       out_last_o,
    output logic [3:0] count_o
`ifdef RS_ENC_ERR_INJECT_EN
    ,
    input  logic       err_en_i,
    input  logic [3:0] err_pos_i,
    input  logic [3:0] err_val_i
`endif
);

    typedef enum logic [0:0] {StMsg, StParity} phase_e;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] t;
        p = 4'h0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ t;
            // Multiply by x, folding x^4 back in as x + 1.
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    phase_e     phase_q, phase_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] r3_q, r3_d, r2_q, r2_d, r1_q, r1_d, r0_q, r0_d;
    logic [3:0] out_sym_q, out_sym_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] count_q, count_d;

    logic       slot_free;
    logic       accept;
    logic [3:0] fb;
    logic [3:0] inj_mask;

    assign slot_free  = !out_valid_q || out_ready_i;
    assign in_ready_o = (phase_q == StMsg) && slot_free;
    assign accept     = in_valid_i && in_ready_o;
    assign fb         = in_symbol_i ^ r3_q;

`ifdef RS_ENC_ERR_INJECT_EN
    logic       err_en_q, err_en_d;
    logic [3:0] err_pos_q, err_pos_d;
    logic [3:0] err_val_q, err_val_d;
    logic       first_acc;
    logic       inj_en;
    logic [3:0] inj_pos, inj_val;

    // Symbol 0 uses the live inputs; later symbols use the values captured with it.
    always_comb begin
        first_acc = accept && (cnt_q == 4'd0);
        err_en_d  = first_acc ? err_en_i  : err_en_q;
        err_pos_d = first_acc ? err_pos_i : err_pos_q;
        err_val_d = first_acc ? err_val_i : err_val_q;
        inj_en    = first_acc ? err_en_i  : err_en_q;
        inj_pos   = first_acc ? err_pos_i : err_pos_q;
        inj_val   = first_acc ? err_val_i : err_val_q;
        inj_mask  = (inj_en && (inj_pos == cnt_q)) ? inj_val : 4'h0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_en_q  <= 1'b0;
            err_pos_q <= 4'h0;
            err_val_q <= 4'h0;
        end else begin
            err_en_q  <= err_en_d;
            err_pos_q <= err_pos_d;
            err_val_q <= err_val_d;
        end
    end
`else
    assign inj_mask = 4'h0;
`endif

    always_comb begin
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        r3_d        = r3_q;
        r2_d        = r2_q;
        r1_d        = r1_q;
        r0_d        = r0_q;
        out_sym_d   = out_sym_q;
        out_valid_d = out_valid_q;
        count_d     = count_q;

        unique case (phase_q)
            StMsg: begin
                if (accept) begin
                    out_sym_d   = in_symbol_i ^ inj_mask;
                    out_valid_d = 1'b1;
                    count_d     = cnt_q;
                    r3_d        = r2_q ^ gf_mul(fb, G3);
                    r2_d        = r1_q ^ gf_mul(fb, G2);
                    r1_d        = r0_q ^ gf_mul(fb, G1);
                    r0_d        = gf_mul(fb, G0);
                    cnt_d       = cnt_q + 4'd1;
                    if (cnt_q == 4'd10) phase_d = StParity;
                end else if (out_ready_i) begin
                    out_valid_d = 1'b0;
                end
            end
            StParity: begin
                if (slot_free) begin
                    out_sym_d   = r3_q ^ inj_mask;
                    out_valid_d = 1'b1;
                    count_d     = cnt_q;
                    r3_d        = r2_q;
                    r2_d        = r1_q;
                    r1_d        = r0_q;
                    r0_d        = 4'h0;
                    if (cnt_q == 4'd14) begin
                        cnt_d   = 4'd0;
                        phase_d = StMsg;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            default: phase_d = StMsg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q     <= StMsg;
            cnt_q       <= 4'd0;
            r3_q        <= 4'h0;
            r2_q        <= 4'h0;
            r1_q        <= 4'h0;
            r0_q        <= 4'h0;
            out_sym_q   <= 4'h0;
            out_valid_q <= 1'b0;
            count_q     <= 4'd0;
        end else begin
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            r3_q        <= r3_d;
            r2_q        <= r2_d;
            r1_q        <= r1_d;
            r0_q        <= r0_d;
            out_sym_q   <= out_sym_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    assign out_serial_o = out_sym_q;
    assign out_valid_o  = out_valid_q;
    assign count_o      = count_q;
    assign out_last_o   = out_valid_q && (count_q == 4'd14);

endmodule

// File: tb/tb_rs_encoder_15_11.sv
// Scoreboard bench for rs_encoder_15_11: directed codewords, stalls/gaps, mid-codeword reset.
module tb_rs_encoder_15_11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_symbol = 4'h0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out_serial;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic [3:0] count;
`ifdef RS_ENC_ERR_INJECT_EN
    logic       err_en = 1'b0;
    logic [3:0] err_pos = 4'h0;
    logic [3:0] err_val = 4'h0;
`endif

    always #5 clk = ~clk;

    rs_encoder_15_11 dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_symbol_i  (in_symbol),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .out_serial_o (out_serial),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_last_o   (out_last),
        .count_o      (count)
`ifdef RS_ENC_ERR_INJECT_EN
        ,
        .err_en_i     (err_en),
        .err_pos_i    (err_pos),
        .err_val_i    (err_val)
`endif
    );

    typedef struct {
        logic [3:0] sym;
        logic [3:0] cnt;
        bit         known;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   stall_mode = 1'b0;
    bit   gap_mode = 1'b0;
    bit   synd_zero = 1'b1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] xtime(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] mul_apow(input logic [3:0] a, input int j);
        logic [3:0] t;
        t = a;
        for (int i = 0; i < j; i++) t = xtime(t);
        return t;
    endfunction

    // Monitor: scoreboard pop, hold-while-stalled check, syndromes per codeword.
    initial begin : monitor
        logic [3:0] cw[15];
        logic [3:0] prev_sym, prev_cnt, s;
        bit         prev_stall;
        bit         any_nz;
        exp_t       e;
        prev_stall = 1'b0;
        prev_sym   = 4'h0;
        prev_cnt   = 4'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("stall_valid", 8'(out_valid), 8'd1);
                chk("stall_sym", 8'(out_serial), 8'(prev_sym));
                chk("stall_count", 8'(count), 8'(prev_cnt));
            end
            if (out_valid) begin
                chk("last", 8'(out_last), 8'(count == 4'd14));
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_output: got sym %0h count %0d expected none",
                                 out_serial, count);
                    end else begin
                        e = sb_q.pop_front();
                        chk("count", 8'(count), 8'(e.cnt));
                        if (e.known) chk("symbol", 8'(out_serial), 8'(e.sym));
                    end
                    if (count < 4'd15) cw[count] = out_serial;
                    if (count == 4'd14) begin
                        any_nz = 1'b0;
                        for (int j = 0; j < 4; j++) begin
                            s = 4'h0;
                            for (int k = 0; k < 15; k++) s = mul_apow(s, j) ^ cw[k];
                            if (synd_zero) chk("syndrome", 8'(s), 8'd0);
                            if (s != 4'h0) any_nz = 1'b1;
                        end
                        if (!synd_zero) chk("syndrome_nonzero", 8'(any_nz), 8'd1);
                    end
                end
            end else begin
                chk("last_idle", 8'(out_last), 8'd0);
            end
            prev_stall = out_valid && !out_ready;
            prev_sym   = out_serial;
            prev_cnt   = count;
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_sym(input logic [3:0] s);
        int n;
        bit acc;
        if (gap_mode) repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        in_symbol = s;
        in_valid  = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got no in_ready expected accept of %0h", s);
        end
    endtask

    task automatic send_codeword(input logic [43:0] msg, input logic [59:0] cw_exp,
                                 input bit par_known);
        for (int k = 0; k < 15; k++) begin
            exp_t e;
            e.sym   = cw_exp[59-4*k -: 4];
            e.cnt   = 4'(k);
            e.known = (k < 11) || par_known;
            sb_q.push_back(e);
        end
        for (int k = 0; k < 11; k++) send_sym(msg[43-4*k -: 4]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 8'(sb_q.size() == 0), 8'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        chk("rst_valid", 8'(out_valid), 8'd0);
        chk("rst_serial", 8'(out_serial), 8'd0);
        chk("rst_count", 8'(count), 8'd0);
        chk("rst_last", 8'(out_last), 8'd0);
        chk("rst_in_ready", 8'(in_ready), 8'd1);
    endtask

    // Directed vectors: message and full expected codeword (c14 first).
    localparam int NVec = 5;
    logic [43:0] vec_msg[NVec] = '{44'h0, 44'h1, 44'h2, 44'h3, 44'h10};
    logic [59:0] vec_cw[NVec]  = '{60'h0,
                                   {44'h1, 16'hF31C},
                                   {44'h2, 16'hD62B},
                                   {44'h3, 16'h2537},
                                   {44'h10, 16'h9338}};

    initial begin : main
        logic [43:0] m;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int v = 0; v < NVec; v++) send_codeword(vec_msg[v], vec_cw[v], 1'b1);
        drain();

        stall_mode = 1'b1;
        gap_mode   = 1'b1;
        for (int v = 0; v < NVec; v++) send_codeword(vec_msg[v], vec_cw[v], 1'b1);
        for (int r = 0; r < 20; r++) begin
            m = 44'({$urandom(), $urandom()});
            send_codeword(m, {m, 16'h0}, 1'b0);
        end
        drain();
        stall_mode = 1'b0;
        gap_mode   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Partial codeword, then reset: the next codeword must start clean.
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            e.sym   = 4'(k + 1);
            e.cnt   = 4'(k);
            e.known = 1'b1;
            sb_q.push_back(e);
        end
        for (int k = 0; k < 6; k++) send_sym(4'(k + 1));
        repeat (2) @(posedge clk);
        #1;
        chk("partial_drained", 8'(sb_q.size()), 8'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_codeword(vec_msg[1], vec_cw[1], 1'b1);
        drain();

`ifdef RS_ENC_ERR_INJECT_EN
        synd_zero = 1'b0;
        err_en  = 1'b1;
        err_pos = 4'd3;
        err_val = 4'h7;
        send_codeword(44'h0, 60'h000700000000000, 1'b1);
        err_en = 1'b0;
        drain();
        synd_zero = 1'b1;
        err_en  = 1'b1;
        err_pos = 4'd15;
        err_val = 4'h7;
        send_codeword(44'h0, 60'h0, 1'b1);
        err_en = 1'b0;
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
